// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 read port (AR + R) among NUM_MASTERS requesters, one burst in flight.
// Define AXI4_RD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module axi4_rd_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ID_WIDTH    = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_MASTERS-1:0]          s_arvalid,
    output logic [NUM_MASTERS-1:0]          s_arready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_MASTERS*8-1:0]        s_arlen,
    input  logic [NUM_MASTERS*3-1:0]        s_arsize,
    input  logic [NUM_MASTERS*2-1:0]        s_arburst,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0] s_arid,
    output logic [NUM_MASTERS-1:0]          s_rvalid,
    input  logic [NUM_MASTERS-1:0]          s_rready,
    output logic [DATA_WIDTH-1:0]           s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            s_rlast,
    output logic [ID_WIDTH-1:0]             s_rid,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [ADDR_WIDTH-1:0]           m_araddr,
    output logic [7:0]                      m_arlen,
    output logic [2:0]                      m_arsize,
    output logic [1:0]                      m_arburst,
    output logic [ID_WIDTH-1:0]             m_arid,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic [1:0]                      m_rresp,
    input  logic                            m_rlast,
    input  logic [ID_WIDTH-1:0]             m_rid
);

    localparam int unsigned PtrW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PtrW-1:0]        g_idx;
    logic [PtrW-1:0]        pick_idx;
    logic [PtrW-1:0]        cand_idx;
    logic                   pick_found;
`ifndef AXI4_RD_ARB_FIXED_PRIO_EN
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
`endif

    // Encoded index of the granted requester; requester 0 while nothing is granted.
    always_comb begin
        g_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) g_idx = PtrW'(i);
        end
    end

    always_comb begin
        cand_idx   = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
            cand_idx = PtrW'(i);
`else
            cand_idx = PtrW'((32'(rr_ptr_q) + i) % NUM_MASTERS);
`endif
            if (!pick_found && s_arvalid[cand_idx]) begin
                pick_idx   = cand_idx;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
`ifndef AXI4_RD_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
`ifndef AXI4_RD_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
`ifndef AXI4_RD_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = NUM_MASTERS'(1) << pick_idx;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (s_arvalid[g_idx] && m_arready) state_d = StData;
            end
            StData: begin
                if (m_rvalid && s_rready[g_idx] && m_rlast) begin
                    state_d  = StIdle;
`ifndef AXI4_RD_ARB_FIXED_PRIO_EN
                    // Explicit wrap so non-power-of-two counts rotate correctly.
                    rr_ptr_d = (g_idx == PtrW'(NUM_MASTERS - 1)) ? '0 : g_idx + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_araddr  = s_araddr[g_idx*ADDR_WIDTH +: ADDR_WIDTH];
        m_arlen   = s_arlen[g_idx*8 +: 8];
        m_arsize  = s_arsize[g_idx*3 +: 3];
        m_arburst = s_arburst[g_idx*2 +: 2];
        m_arid    = s_arid[g_idx*ID_WIDTH +: ID_WIDTH];
        s_rdata   = m_rdata;
        s_rresp   = m_rresp;
        s_rlast   = m_rlast;
        s_rid     = m_rid;
        m_arvalid = 1'b0;
        s_arready = '0;
        m_rready  = 1'b0;
        s_rvalid  = '0;
        unique case (state_q)
            StAddr: begin
                m_arvalid        = s_arvalid[g_idx];
                s_arready[g_idx] = m_arready;
            end
            StData: begin
                m_rready        = s_rready[g_idx];
                s_rvalid[g_idx] = m_rvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/axi4_rd_arbiter.md
# axi4_rd_arbiter

Round-robin arbiter that shares one AXI4 read port (AR + R channels) among `NUM_MASTERS` requesters, with one burst in flight at a time. It sits between several read masters (DMA engines, accelerators) and a single AXI4 read slave or interconnect port. It grants one AR request, forwards the burst's R beats back to that requester until the `rlast` handshake, then re-arbitrates.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesters, range 2–8.
- `ADDR_WIDTH`, 16: AXI address width.
- `DATA_WIDTH`, 64: AXI data width.
- `ID_WIDTH`, 4: AXI ID width; passed through unchanged.

Ports:
- `i_clk`  in  1  — single clock.
- `i_rst`  in  1  — reset; synchronous, active-high.
- `s_arvalid`  in  NUM_MASTERS  — per-requester AR valid.
- `s_arready`  out  NUM_MASTERS  — per-requester AR ready.
- `s_araddr`  in  NUM_MASTERS*ADDR_WIDTH  — packed; requester k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `s_arlen`  in  NUM_MASTERS*8  — packed burst lengths.
- `s_arsize`  in  NUM_MASTERS*3  — packed burst sizes.
- `s_arburst`  in  NUM_MASTERS*2  — packed burst types.
- `s_arid`  in  NUM_MASTERS*ID_WIDTH  — packed IDs.
- `s_rvalid`  out  NUM_MASTERS  — per-requester R valid.
- `s_rready`  in  NUM_MASTERS  — per-requester R ready.
- `s_rdata` / `s_rresp` / `s_rlast` / `s_rid`  out  DATA_WIDTH / 2 / 1 / ID_WIDTH  — broadcast to all requesters; qualify with `s_rvalid[k]`.
- `m_arvalid` / `m_arready`  out / in  1  — downstream AR handshake.
- `m_araddr` / `m_arlen` / `m_arsize` / `m_arburst` / `m_arid`  out  ADDR_WIDTH / 8 / 3 / 2 / ID_WIDTH  — downstream AR fields.
- `m_rvalid` / `m_rready`  in / out  1  — downstream R handshake.
- `m_rdata` / `m_rresp` / `m_rlast` / `m_rid`  in  DATA_WIDTH / 2 / 1 / ID_WIDTH  — downstream R payload.

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: `grant` (one-hot, NUM_MASTERS) and `rr_ptr` (`$clog2(NUM_MASTERS)` bits).
- IDLE: if any `s_arvalid` bit is set, select the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_MASTERS. Register it into `grant`, then go to ADDR. If no bit is set, stay in IDLE.
- ADDR:
  - `m_ar*` equals the granted requester's `s_ar*` fields; `m_arvalid = s_arvalid[g]`.
  - `s_arready[g] = m_arready`; all other `s_arready` bits are 0.
  - On `m_arvalid & m_arready`, go to DATA.
- DATA:
  - `s_rvalid[g] = m_rvalid` and `m_rready = s_rready[g]`; all other `s_rvalid` bits are 0.
  - On `m_rvalid & m_rready & m_rlast`, go to IDLE and set `rr_ptr = (g+1) mod NUM_MASTERS`. The wrap is explicit, not a power-of-two truncation.
- Outside ADDR: `m_arvalid = 0` and all `s_arready` bits are 0.
- Outside DATA: `m_rready = 0` and all `s_rvalid` bits are 0.
- `s_rdata`, `s_rresp`, `s_rlast` and `s_rid` are always a combinational copy of the `m_r*` payload.
- A requester that is not granted sees no ready and no valid; it must hold its request per AXI4 rules.
- `arlen = 0` (single beat) is legal: the first R beat carries `rlast` and ends DATA.
- A `m_rlast` completion and a new `s_arvalid` in the same cycle: the FSM goes to IDLE, and arbitration happens in the following cycle.
- Reset, including mid-burst: state becomes IDLE, `grant = 0`, `rr_ptr = 0`, and every valid/ready output is 0 in the next cycle. Any outstanding downstream burst is abandoned, so the downstream slave must be reset together with this block.

## Timing
- Output reset values: `s_arready = 0`, `s_rvalid = 0`, `m_arvalid = 0`, `m_rready = 0`. The `m_ar*` fields are don't-care while `m_arvalid = 0`; they are driven from requester 0.
- Grant latency: `s_arvalid` rising in IDLE at cycle t gives `m_arvalid = 1` at t+1.
- AR and R paths are combinational pass-through once granted; no added latency per beat.
- Minimum bubble between bursts: 1 cycle (the IDLE arbitration cycle).
- Throughput: one burst in flight; R beats run at full rate while `m_rvalid & s_rready[g]`.

## Configuration
- Macro: `AXI4_RD_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority; the lowest-index requester with `s_arvalid` set always wins. `rr_ptr` is not implemented.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single request: with NUM_MASTERS=4, requester 2 issues `araddr=0x1200`, `arlen=3` → `m_araddr=0x1200` one cycle later. Four beats are routed only to `s_rvalid[2]`, and the FSM returns to IDLE after the `rlast` handshake.
- Round-robin fairness: all four requesters assert continuously with `arlen=0` → grant order 0,1,2,3,0. Exactly one IDLE cycle separates bursts.
- Backpressure: `m_arready` is held low for 5 cycles, then `s_rready[1]` toggles during a 4-beat burst → AR fields stay stable, no beat is lost or duplicated, and `m_rready` tracks `s_rready[1]`.
- Wrap and pointer: after a burst from requester 3 completes, requesters 0 and 3 both assert → requester 0 is granted.
- Reset mid-burst: assert `i_rst` during beat 2 of an 8-beat burst → all valid/ready outputs are 0 on the next cycle. After release, requester 0 wins ties.
- `AXI4_RD_ARB_FIXED_PRIO_EN` defined: requesters 1 and 3 assert continuously → requester 1 is granted every time.
